screen_rect_scanner: RTL and testbench
======================================

// Module: screen_rect_scanner
// PURPOSE
//  Responder side of the screen interface used by the graphics primitives. On
//  screen_start it raster-scans the requested bounding box and presents each
//  pixel's (x,y) with its current framebuffer colour. It then writes the
//  caller's returned colour back and pulses screen_done at the end of the box.
//  Sits between a primitive (triangle fill etc.) and the framebuffer RAM.
// PARAMETERS
//  WIDTH         8    coordinate/range width
//  COLOUR_WIDTH  3    pixel colour width
//  SCREEN_W      160  visible columns; x >= SCREEN_W is clipped
//  SCREEN_H      120  visible rows; y >= SCREEN_H is clipped
//  ADDR_WIDTH    15   framebuffer address width; addr = y*SCREEN_W + x
// PORTS
//  clock              in   1             system clock; all logic on posedge
//  reset              in   1             synchronous, active-high
//  screen_start       in   1             level request from primitive
//  new_screen_colour  in   COLOUR_WIDTH  colour to write, comb. from caller
//  screen_x_min       in   WIDTH         box left edge
//  screen_y_min       in   WIDTH         box top edge
//  screen_x_range     in   WIDTH         box width-1 (inclusive span)
//  screen_y_range     in   WIDTH         box height-1 (inclusive span)
//  screen_x           out  WIDTH         current pixel x
//  screen_y           out  WIDTH         current pixel y
//  old_screen_colour  out  COLOUR_WIDTH  framebuffer colour at (x,y)
//  screen_done        out  1             one-cycle pulse: box complete
//  mem_addr           out  ADDR_WIDTH    framebuffer address
//  mem_rdata          in   COLOUR_WIDTH  read data, valid 1 cycle after addr
//  mem_wdata          out  COLOUR_WIDTH  write data
//  mem_we             out  1             write enable
// BEHAVIOUR
//  - Reset values: screen_x=0, screen_y=0, screen_done=0, mem_addr=0,
//    mem_wdata=0, mem_we=0. old_screen_colour=0 except in S_WRITE.
//  - FSM: S_IDLE -> S_READ on screen_start=1. Latch x_min, y_min, end_x and
//    end_y, where end = min + range computed in WIDTH+1 bits (no wrap).
//    S_READ: mem_addr driven for (x,y), mem_we=0 -> S_WRITE.
//    S_WRITE: old_screen_colour=mem_rdata; mem_wdata=new_screen_colour;
//    mem_we=1 unless clipped. Then advance the pixel.
//    Advance order: x inner, y outer. If x==end_x && y==end_y -> S_DONE;
//    otherwise -> S_READ with the next pixel.
//    S_DONE: screen_done=1 for exactly one cycle -> S_IDLE.
//  - Cost: 2 cycles/pixel; done appears 2*(rx+1)*(ry+1) cycles after the
//    first S_READ. Address uses WIDTH+1-bit x/y; no coordinate wrap past 2^WIDTH.
//  - Clipped pixel (x>=SCREEN_W or y>=SCREEN_H): still takes 2 cycles.
//    mem_we=0, old_screen_colour=0, mem_addr held at 0.
//  - screen_start is ignored while busy; box inputs are sampled only at the
//    start edge. Start still high in S_IDLE after done begins a new scan, so
//    callers must drop start on or before the done cycle.
//  - Reset mid-scan: S_IDLE on the next edge, mem_we=0, no done pulse.
//  - range=0 on both axes: single pixel; done 2 cycles after start.
// CONFIGURATION
//  SCREEN_SKIP_UNCHANGED_EN: when defined, mem_we is suppressed in S_WRITE if
//  new_screen_colour==mem_rdata. Cycle timing is unchanged.
//  Undefined: every unclipped pixel is written.
// STRUCTURE
//  Shared header graphics_defs.vh holds SCREEN_W/SCREEN_H/ADDR_WIDTH defaults
//  and the scanner state encodings (S_IDLE,S_READ,S_WRITE,S_DONE).
//  Sub-module screen_addr_calc: combinational y*SCREEN_W+x plus clip flag.
// TESTING
//  1. x_min=10,y_min=20,ranges=0, new=5 -> one write addr 3210 data 5;
//     done 2 cycles after start, high 1 cycle.
//  2. box (0,0) range (2,1), RAM preloaded -> 6 writes in order
//     (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); done at cycle 12.
//  3. x_min=158,range=3,y=0 -> writes only x=158,159; x=160,161 give
//     mem_we=0; 8 cycles to done.
//  4. reset asserted at 3rd pixel -> mem_we=0 and S_IDLE next edge, no done;
//     a fresh start then scans fully.
//  5. x_min=250,range=10 (WIDTH=8) -> end_x=260, no wrap; all pixels are
//     clipped; 22 cycles to done.
//  6. SCREEN_SKIP_UNCHANGED_EN, RAM holds 3 and new=3 -> zero writes, same
//     timing; new=4 -> all pixels written.

Source files
------------

// File: rtl/screen_rect_scanner_pkg.sv
// Shared defaults and scanner state encodings for the screen rectangle scanner.
package screen_rect_scanner_pkg;

  localparam int unsigned DEF_WIDTH        = 8;
  localparam int unsigned DEF_COLOUR_WIDTH = 3;
  localparam int unsigned DEF_SCREEN_W     = 160;
  localparam int unsigned DEF_SCREEN_H     = 120;
  localparam int unsigned DEF_ADDR_WIDTH   = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/screen_addr_calc.sv
// Framebuffer address y*SCREEN_W+x for an unwrapped coordinate, plus off-screen clip flag.
module screen_addr_calc
  import screen_rect_scanner_pkg::*;
#(
  parameter int unsigned COORD_W    = DEF_WIDTH + 1,
  parameter int unsigned SCREEN_W   = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H   = DEF_SCREEN_H,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [COORD_W-1:0]    x,
  input  logic [COORD_W-1:0]    y,
  output logic [ADDR_WIDTH-1:0] addr_c,
  output logic                  clip_c
);

  always_comb begin
    clip_c = (32'(x) >= SCREEN_W) || (32'(y) >= SCREEN_H);
    addr_c = ADDR_WIDTH'(32'(y) * SCREEN_W + 32'(x));
  end

endmodule

// File: rtl/screen_rect_scanner.sv
// Raster-scans a bounding box, presents each pixel's stored colour and writes back the caller's colour.
// Build option SCREEN_SKIP_UNCHANGED_EN suppresses writes whose colour equals the stored one.
module screen_rect_scanner
  import screen_rect_scanner_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned COLOUR_WIDTH = DEF_COLOUR_WIDTH,
  parameter int unsigned SCREEN_W     = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H     = DEF_SCREEN_H,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    screen_start,
  input  logic [COLOUR_WIDTH-1:0] new_screen_colour,
  input  logic [WIDTH-1:0]        screen_x_min,
  input  logic [WIDTH-1:0]        screen_y_min,
  input  logic [WIDTH-1:0]        screen_x_range,
  input  logic [WIDTH-1:0]        screen_y_range,
  output logic [WIDTH-1:0]        screen_x,
  output logic [WIDTH-1:0]        screen_y,
  output logic [COLOUR_WIDTH-1:0] old_screen_colour,
  output logic                    screen_done,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [COLOUR_WIDTH-1:0] mem_rdata,
  output logic [COLOUR_WIDTH-1:0] mem_wdata,
  output logic                    mem_we
);

  localparam int unsigned CW = WIDTH + 1;

  scan_state_t state, state_nxt;

  logic [CW-1:0]         x_min_q, end_x, end_y;
  logic [CW-1:0]         cur_x, cur_y;
  logic [CW-1:0]         nxt_x, nxt_y;
  logic                  load_pixel;
  logic                  last_pixel;
  logic                  clip_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] calc_addr;
  logic                  calc_clip;

  // Address/clip evaluated for the pixel about to be loaded, then registered
  screen_addr_calc #(
    .COORD_W   (CW),
    .SCREEN_W  (SCREEN_W),
    .SCREEN_H  (SCREEN_H),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_calc (
    .x     (nxt_x),
    .y     (nxt_y),
    .addr_c(calc_addr),
    .clip_c(calc_clip)
  );

  assign last_pixel  = (cur_x == end_x) && (cur_y == end_y);
  assign screen_x    = cur_x[WIDTH-1:0];
  assign screen_y    = cur_y[WIDTH-1:0];
  assign mem_addr    = addr_q;
  assign screen_done = done_q;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state, next pixel and the read-modify-write strobes
  always_comb begin
    state_nxt         = state;
    load_pixel        = 1'b0;
    nxt_x             = cur_x;
    nxt_y             = cur_y;
    old_screen_colour = '0;
    mem_wdata         = '0;
    mem_we            = 1'b0;
    case (state)
      S_IDLE: begin
        if (screen_start) begin
          state_nxt  = S_READ;
          load_pixel = 1'b1;
          nxt_x      = CW'(screen_x_min);
          nxt_y      = CW'(screen_y_min);
        end
      end
      S_READ: state_nxt = S_WRITE;
      S_WRITE: begin
        mem_wdata = new_screen_colour;
        if (!clip_q) begin
          old_screen_colour = mem_rdata;
          mem_we            = !reset;
`ifdef SCREEN_SKIP_UNCHANGED_EN
          if (new_screen_colour == mem_rdata) mem_we = 1'b0;
`endif
        end
        if (last_pixel) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt  = S_READ;
          load_pixel = 1'b1;
          if (cur_x == end_x) begin
            nxt_x = x_min_q;
            nxt_y = cur_y + CW'(1);
          end else begin
            nxt_x = cur_x + CW'(1);
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Box bounds are one bit wider than the inputs so end never wraps
  always_ff @(posedge clock) begin
    if (reset) begin
      x_min_q <= '0;
      end_x   <= '0;
      end_y   <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
      clip_q  <= 1'b0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_nxt == S_DONE);
      if (state == S_IDLE && screen_start) begin
        x_min_q <= CW'(screen_x_min);
        end_x   <= CW'(screen_x_min) + CW'(screen_x_range);
        end_y   <= CW'(screen_y_min) + CW'(screen_y_range);
      end
      if (load_pixel) begin
        cur_x  <= nxt_x;
        cur_y  <= nxt_y;
        clip_q <= calc_clip;
        addr_q <= calc_clip ? '0 : calc_addr;
      end
    end
  end

endmodule

// File: tb/tb_screen_rect_scanner.sv
// Randomized bench for screen_rect_scanner with a per-cycle behavioural reference model.
module tb_screen_rect_scanner;

  localparam int W     = 8;
  localparam int CLW   = 3;
  localparam int SW    = 160;
  localparam int SH    = 120;
  localparam int AW    = 15;
  localparam int RAM_N = 1 << AW;

`ifdef SCREEN_SKIP_UNCHANGED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           screen_start = 1'b0;
  logic [CLW-1:0] new_screen_colour;
  logic [W-1:0]   screen_x_min = '0, screen_y_min = '0, screen_x_range = '0, screen_y_range = '0;
  logic [W-1:0]   screen_x, screen_y;
  logic [CLW-1:0] old_screen_colour;
  logic           screen_done;
  logic [AW-1:0]  mem_addr;
  logic [CLW-1:0] mem_rdata = '0;
  logic [CLW-1:0] mem_wdata;
  logic           mem_we;

  logic [CLW-1:0] ram     [RAM_N];
  logic [CLW-1:0] ref_ram [RAM_N];

  bit             new_mode  = 1'b0;
  logic [CLW-1:0] new_const = '0;
  bit             fill_go   = 1'b0;
  bit             fill_kind = 1'b0;
  int unsigned    fill_seed = 0;
  bit             chk_en    = 1'b0;
  bit             flush     = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int wr_addr_log[$];
  int wr_data_log[$];

  typedef struct {
    int x;
    int y;
    bit clip;
    int addr;
    bit wr;
    bit done;
  } rec_t;
  rec_t exp_q[$];

  screen_rect_scanner dut (
    .clock            (clock),
    .reset            (reset),
    .screen_start     (screen_start),
    .new_screen_colour(new_screen_colour),
    .screen_x_min     (screen_x_min),
    .screen_y_min     (screen_y_min),
    .screen_x_range   (screen_x_range),
    .screen_y_range   (screen_y_range),
    .screen_x         (screen_x),
    .screen_y         (screen_y),
    .old_screen_colour(old_screen_colour),
    .screen_done      (screen_done),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata),
    .mem_wdata        (mem_wdata),
    .mem_we           (mem_we)
  );

  always #5 clock = ~clock;

  // Caller: combinational colour from the presented old colour
  assign new_screen_colour = new_mode ? (old_screen_colour + CLW'(1)) : new_const;

  function automatic logic [CLW-1:0] fill_fn(input int i, input bit kind, input int unsigned seed);
    int unsigned h;
    if (kind) return CLW'(seed);
    h = 32'(i) * 32'd2654435761 + seed;
    return CLW'(h >> 17);
  endfunction

  // Framebuffer RAM: one-cycle read latency, write on the same address
  always @(posedge clock) begin
    if (fill_go) begin
      for (int i = 0; i < RAM_N; i++) ram[i] <= fill_fn(i, fill_kind, fill_seed);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  function automatic void check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic compare_loop();
    rec_t           r;
    logic [CLW-1:0] e_old, e_new;
    bit             e_we;
    forever begin
      @(negedge clock);
      if (fill_go) for (int i = 0; i < RAM_N; i++) ref_ram[i] = fill_fn(i, fill_kind, fill_seed);
      if (flush) exp_q.delete();
      if (chk_en) begin
        if (exp_q.size() == 0) begin
          check("idle_done", 32'(screen_done), 0);
          check("idle_we", 32'(mem_we), 0);
          check("idle_old", 32'(old_screen_colour), 0);
        end else begin
          r = exp_q.pop_front();
          check("done", 32'(screen_done), 32'(r.done));
          if (r.done) begin
            check("done_we", 32'(mem_we), 0);
          end else begin
            check("x", 32'(screen_x), 32'(r.x % 256));
            check("y", 32'(screen_y), 32'(r.y % 256));
            check("addr", 32'(mem_addr), 32'(r.addr));
            if (!r.wr) begin
              check("read_we", 32'(mem_we), 0);
              check("read_old", 32'(old_screen_colour), 0);
            end else begin
              e_old = r.clip ? '0 : ref_ram[r.addr];
              e_new = new_mode ? (e_old + CLW'(1)) : new_const;
              e_we  = !r.clip && !reset && !(SKIP && (e_new == e_old));
              check("old", 32'(old_screen_colour), 32'(e_old));
              check("wdata", 32'(mem_wdata), 32'(e_new));
              check("we", 32'(mem_we), 32'(e_we));
              if (e_we) ref_ram[r.addr] = e_new;
              if (mem_we) begin
                wr_cnt++;
                wr_addr_log.push_back(int'(mem_addr));
                wr_data_log.push_back(int'(mem_wdata));
              end
            end
          end
        end
      end
    end
  endtask

  task automatic fill(input bit kind, input int unsigned seed);
    @(posedge clock); #1;
    fill_kind = kind;
    fill_seed = seed;
    fill_go   = 1'b1;
    @(posedge clock); #1;
    fill_go = 1'b0;
  endtask

  // Expected pixel sequence: x inner, y outer, two cycles each, then done
  task automatic push_box(input int xmin, input int ymin, input int rx, input int ry);
    rec_t r;
    for (int y = ymin; y <= ymin + ry; y++) begin
      for (int x = xmin; x <= xmin + rx; x++) begin
        r.x    = x;
        r.y    = y;
        r.clip = (x >= SW) || (y >= SH);
        r.addr = r.clip ? 0 : y * SW + x;
        r.done = 1'b0;
        r.wr   = 1'b0;
        exp_q.push_back(r);
        r.wr   = 1'b1;
        exp_q.push_back(r);
      end
    end
    r = '{default: 0};
    r.done = 1'b1;
    exp_q.push_back(r);
  endtask

  // Leaves the bench just after the start-sampling edge with the box queued
  task automatic start_box(input int xmin, input int ymin, input int rx, input int ry);
    @(posedge clock); #1;
    screen_x_min   = W'(xmin);
    screen_y_min   = W'(ymin);
    screen_x_range = W'(rx);
    screen_y_range = W'(ry);
    screen_start   = 1'b1;
    @(posedge clock); #1;
    screen_start   = 1'b0;
    screen_x_min   = W'($urandom);
    screen_y_min   = W'($urandom);
    screen_x_range = W'($urandom);
    screen_y_range = W'($urandom);
    push_box(xmin, ymin, rx, ry);
  endtask

  task automatic run_box(input int xmin, input int ymin, input int rx, input int ry, output int lat);
    start_box(xmin, ymin, rx, ry);
    lat = 0;
    while (!screen_done && lat < 4000) begin
      @(posedge clock); #1;
      lat++;
    end
    check("done_seen", 32'(screen_done), 1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    int lat, base, rx, ry, xmin, ymin, bad;
    fork
      compare_loop();
    join_none

    fill(1'b1, 0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_x", 32'(screen_x), 0);
    check("rst_y", 32'(screen_y), 0);
    check("rst_done", 32'(screen_done), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_old", 32'(old_screen_colour), 0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Single pixel
    new_mode = 1'b0; new_const = 3'd5;
    base = wr_cnt;
    run_box(10, 20, 0, 0, lat);
    check("t1_lat", 32'(lat), 2);
    check("t1_writes", 32'(wr_cnt - base), 1);
    if (wr_addr_log.size() > base) begin
      check("t1_addr", 32'(wr_addr_log[base]), 3210);
      check("t1_data", 32'(wr_data_log[base]), 5);
    end

    // 3x2 box from origin over preloaded RAM
    fill(1'b0, 32'h1234);
    new_mode = 1'b1;
    base = wr_cnt;
    run_box(0, 0, 2, 1, lat);
    check("t2_lat", 32'(lat), 12);
    check("t2_writes", 32'(wr_cnt - base), 6);
    if (wr_addr_log.size() >= base + 6) begin
      check("t2_a0", 32'(wr_addr_log[base]), 0);
      check("t2_a2", 32'(wr_addr_log[base + 2]), 2);
      check("t2_a3", 32'(wr_addr_log[base + 3]), 160);
      check("t2_a5", 32'(wr_addr_log[base + 5]), 162);
    end

    // Right-edge clipping
    base = wr_cnt;
    run_box(158, 0, 3, 0, lat);
    check("t3_lat", 32'(lat), 8);
    check("t3_writes", 32'(wr_cnt - base), 2);
    if (wr_addr_log.size() >= base + 2) check("t3_a1", 32'(wr_addr_log[base + 1]), 159);

    // Reset during the third pixel, then a full rescan
    base = wr_cnt;
    start_box(5, 5, 3, 2);
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    flush = 1'b1;
    check("t4_x", 32'(screen_x), 0);
    check("t4_addr", 32'(mem_addr), 0);
    check("t4_done", 32'(screen_done), 0);
    check("t4_we", 32'(mem_we), 0);
    @(negedge clock); #1;
    flush = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    check("t4_partial_writes", 32'(wr_cnt - base), 2);
    base = wr_cnt;
    run_box(5, 5, 3, 2, lat);
    check("t4_lat", 32'(lat), 24);
    check("t4_writes", 32'(wr_cnt - base), 12);

    // Box past 2^WIDTH: fully clipped, no wrap
    base = wr_cnt;
    run_box(250, 0, 10, 0, lat);
    check("t5_lat", 32'(lat), 22);
    check("t5_writes", 32'(wr_cnt - base), 0);

    // Unchanged colour
    fill(1'b1, 3);
    new_mode = 1'b0; new_const = 3'd3;
    base = wr_cnt;
    run_box(20, 30, 3, 2, lat);
    check("t6_lat", 32'(lat), 24);
    check("t6_same_writes", 32'(wr_cnt - base), SKIP ? 0 : 12);
    new_const = 3'd4;
    base = wr_cnt;
    run_box(20, 30, 3, 2, lat);
    check("t6_diff_writes", 32'(wr_cnt - base), 12);

    // Random boxes, some straddling the bottom and right edges
    for (int k = 0; k < 25; k++) begin
      if (k % 5 == 0) fill(1'b0, $urandom);
      new_mode  = bit'($urandom_range(0, 1));
      new_const = CLW'($urandom);
      xmin = int'($urandom_range(0, 255));
      ymin = (k % 3 == 0) ? int'($urandom_range(110, 255)) : int'($urandom_range(0, 125));
      rx   = int'($urandom_range(0, 9));
      ry   = int'($urandom_range(0, 4));
      run_box(xmin, ymin, rx, ry, lat);
      check("rand_lat", 32'(lat), 32'(2 * (rx + 1) * (ry + 1)));
    end

    bad = 0;
    for (int i = 0; i < RAM_N; i++) if (ram[i] != ref_ram[i]) bad++;
    check("ram_final", 32'(bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
